// File: rtl/regfile_port_sequencer.sv
// Single master of the 16-entry register file: post-reset init sweep, then
// valid/ready read / write / write-then-read requests with a registered response.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | sweeping INIT_VAL into registers 0..15, requests blocked
//   ST_IDLE | no response pending, any request accepted
//   ST_RESP | response held until rsp_ready; new request only on drain
module regfile_port_sequencer #(
   parameter int                DATA_W   = 16,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [3:0]        req_src1,
   input  logic [3:0]        req_src2,
   input  logic [3:0]        req_dst,
   input  logic [DATA_W-1:0] req_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data1,
   output logic [DATA_W-1:0] rsp_data2,
   output logic              init_done,
   output logic              err_op,
   output logic [3:0]        rf_srcReg_1,
   output logic [3:0]        rf_srcReg_2,
   output logic [3:0]        rf_dstReg,
   output logic              rf_writeReg,
   output logic [DATA_W-1:0] rf_dstData,
   input  logic [DATA_W-1:0] rf_srcData_1,
   input  logic [DATA_W-1:0] rf_srcData_2
);

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RESP} state_t;

   localparam logic [1:0] OP_RD   = 2'b00;
   localparam logic [1:0] OP_WR   = 2'b01;
   localparam logic [1:0] OP_WRRD = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   state_t            state, state_nxt;
   logic [3:0]        sweep_cnt;
   logic              fire;
   logic              is_wr;
   logic              is_rd;
   logic [DATA_W-1:0] byp_data1, byp_data2;

   always_comb begin
      is_wr = (req_op == OP_WR) || (req_op == OP_WRRD);
      is_rd = (req_op == OP_RD) || (req_op == OP_WRRD);

      req_ready = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready);
      fire      = req_valid && req_ready;

      rf_srcReg_1 = req_src1;
      rf_srcReg_2 = req_src2;
      rf_dstReg   = req_dst;
      rf_dstData  = req_data;
      rf_writeReg = fire && is_wr;

      // The file may not write through, so a same-cycle write must be forwarded.
      byp_data1 = ((req_op == OP_WRRD) && (req_src1 == req_dst)) ? req_data : rf_srcData_1;
      byp_data2 = ((req_op == OP_WRRD) && (req_src2 == req_dst)) ? req_data : rf_srcData_2;

      state_nxt = state;
      case (state)
         ST_INIT: begin
            rf_writeReg = 1'b1;
            rf_dstReg   = sweep_cnt;
            rf_dstData  = INIT_VAL;
            if (sweep_cnt == 4'hF) state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (fire && is_rd) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready && !(fire && is_rd)) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_INIT;
         sweep_cnt <= '0;
         rsp_valid <= 1'b0;
         rsp_data1 <= '0;
         rsp_data2 <= '0;
         init_done <= 1'b0;
         err_op    <= 1'b0;
      end else begin
         state     <= state_nxt;
         rsp_valid <= (state_nxt == ST_RESP);
         if (state == ST_INIT) sweep_cnt <= sweep_cnt + 4'd1;
         if ((state == ST_INIT) && (sweep_cnt == 4'hF)) init_done <= 1'b1;
         if (fire && (req_op == OP_RSVD)) err_op <= 1'b1;
         if (fire && is_rd) begin
            rsp_data1 <= byp_data1;
            rsp_data2 <= byp_data2;
         end
      end
   end

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Directed bench for regfile_port_sequencer with a behavioural, non-write-through
// register file attached to the rf_* ports.
module tb_regfile_port_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [3:0]  req_src1, req_src2, req_dst;
   logic [15:0] req_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data1, rsp_data2;
   logic        init_done, err_op;
   logic [3:0]  rf_srcReg_1, rf_srcReg_2, rf_dstReg;
   logic        rf_writeReg;
   logic [15:0] rf_dstData, rf_srcData_1, rf_srcData_2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_port_sequencer #(.DATA_W(16), .INIT_VAL(16'h0000)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_src1     (req_src1),
      .req_src2     (req_src2),
      .req_dst      (req_dst),
      .req_data     (req_data),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data1    (rsp_data1),
      .rsp_data2    (rsp_data2),
      .init_done    (init_done),
      .err_op       (err_op),
      .rf_srcReg_1  (rf_srcReg_1),
      .rf_srcReg_2  (rf_srcReg_2),
      .rf_dstReg    (rf_dstReg),
      .rf_writeReg  (rf_writeReg),
      .rf_dstData   (rf_dstData),
      .rf_srcData_1 (rf_srcData_1),
      .rf_srcData_2 (rf_srcData_2)
   );

   logic [15:0] rf_mem [16];
   always @(posedge clk) if (rf_writeReg) rf_mem[rf_dstReg] <= rf_dstData;
   assign rf_srcData_1 = rf_mem[rf_srcReg_1];
   assign rf_srcData_2 = rf_mem[rf_srcReg_2];

   typedef struct {
      logic        v;
      logic [1:0]  op;
      logic [3:0]  s1, s2, dst;
      logic [15:0] data;
      logic        rr;
      logic        e_rdy, e_wr;
      logic        e_rv;
      logic [15:0] e_d1, e_d2;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic v, input logic [1:0] op, input logic [3:0] s1, input logic [3:0] s2,
                      input logic [3:0] dst, input logic [15:0] data, input logic rr,
                      input logic e_rdy, input logic e_wr, input logic e_rv,
                      input logic [15:0] e_d1, input logic [15:0] e_d2, input logic e_err);
      vec_t t;
      t.v = v; t.op = op; t.s1 = s1; t.s2 = s2; t.dst = dst; t.data = data; t.rr = rr;
      t.e_rdy = e_rdy; t.e_wr = e_wr; t.e_rv = e_rv; t.e_d1 = e_d1; t.e_d2 = e_d2; t.e_err = e_err;
      vecs.push_back(t);
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] s1, input logic [3:0] s2,
                        input logic [3:0] dst, input logic [15:0] data, input logic rr);
      req_valid = v; req_op = op; req_src1 = s1; req_src2 = s2;
      req_dst = dst; req_data = data; rsp_ready = rr;
   endtask

   // Expects to be entered just after the edge that released reset.
   task automatic sweep_check(input string tag);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         check({tag, " sweep wr"},   rf_writeReg, 1);
         check({tag, " sweep dst"},  rf_dstReg, k);
         check({tag, " sweep data"}, rf_dstData, 16'h0000);
         check({tag, " sweep rdy"},  req_ready, 0);
         check({tag, " sweep rv"},   rsp_valid, 0);
         check({tag, " sweep done"}, init_done, 0);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      #1;
      check({tag, " init_done"}, init_done, 1);
      check({tag, " ready after init"}, req_ready, 1);
      check({tag, " no wr after init"}, rf_writeReg, 0);
   endtask

   initial begin
      // v op s1 s2 dst data rr | rdy wr | rv d1 d2 err
      add(1, 2'b00, 3, 15, 0, 16'h0000, 1,  1, 0,  1, 16'h0000, 16'h0000, 0);
      add(1, 2'b01, 0,  0, 5, 16'hBEEF, 1,  1, 1,  0, 16'h0000, 16'h0000, 0);
      add(1, 2'b00, 5,  5, 0, 16'h0000, 1,  1, 0,  1, 16'hBEEF, 16'hBEEF, 0);
      add(0, 2'b00, 0,  0, 0, 16'h0000, 1,  1, 0,  0, 16'hBEEF, 16'hBEEF, 0);
      add(1, 2'b01, 0,  0, 2, 16'h00AA, 1,  1, 1,  0, 16'hBEEF, 16'hBEEF, 0);
      add(1, 2'b10, 7,  2, 7, 16'h1234, 1,  1, 1,  1, 16'h1234, 16'h00AA, 0);
      add(1, 2'b00, 7,  5, 0, 16'h0000, 1,  1, 0,  1, 16'h1234, 16'hBEEF, 0);
      add(0, 2'b00, 0,  0, 0, 16'h0000, 1,  1, 0,  0, 16'h1234, 16'hBEEF, 0);
      add(1, 2'b00, 5,  2, 0, 16'h0000, 0,  1, 0,  1, 16'hBEEF, 16'h00AA, 0);
      for (int i = 0; i < 3; i++)
         add(1, 2'b01, 0, 0, 9, 16'h5555, 0,  0, 0,  1, 16'hBEEF, 16'h00AA, 0);
      add(1, 2'b01, 0,  0, 9, 16'h5555, 1,  1, 1,  0, 16'hBEEF, 16'h00AA, 0);
      add(1, 2'b00, 9,  9, 0, 16'h0000, 1,  1, 0,  1, 16'h5555, 16'h5555, 0);
      add(1, 2'b11, 0,  0, 4, 16'hFFFF, 1,  1, 0,  0, 16'h5555, 16'h5555, 1);
      add(1, 2'b00, 4,  4, 0, 16'h0000, 1,  1, 0,  1, 16'h0000, 16'h0000, 1);
      for (int i = 0; i < 8; i++)
         add(1, 2'b01, 0, 0, 4'(i), 16'h0100 + 16'(i), 1,  1, 1,  0, 16'h0000, 16'h0000, 1);
      for (int i = 0; i < 8; i++)
         add(1, 2'b00, 4'(i), 4'(7 - i), 0, 16'h0000, 1,  1, 0,  1,
             16'h0100 + 16'(i), 16'h0107 - 16'(i), 1);
      add(0, 2'b00, 0,  0, 0, 16'h0000, 1,  1, 0,  0, 16'h0107, 16'h0100, 1);

      rst = 1'b1;
      drive(1, 2'b00, 0, 0, 0, 16'h0000, 1);
      @(posedge clk); @(posedge clk); #1;
      check("reset rv", rsp_valid, 0);
      check("reset d1", rsp_data1, 16'h0000);
      check("reset err", err_op, 0);
      check("reset done", init_done, 0);
      rst = 1'b0;
      sweep_check("boot");

      foreach (vecs[i]) begin
         drive(vecs[i].v, vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].dst, vecs[i].data, vecs[i].rr);
         @(negedge clk);
         check($sformatf("v%0d req_ready", i), req_ready, vecs[i].e_rdy);
         check($sformatf("v%0d rf_writeReg", i), rf_writeReg, vecs[i].e_wr);
         @(posedge clk); #1;
         check($sformatf("v%0d rsp_valid", i), rsp_valid, vecs[i].e_rv);
         check($sformatf("v%0d rsp_data1", i), rsp_data1, vecs[i].e_d1);
         check($sformatf("v%0d rsp_data2", i), rsp_data2, vecs[i].e_d2);
         check($sformatf("v%0d err_op", i), err_op, vecs[i].e_err);
      end

      // Pending, stalled response when reset hits.
      drive(1, 2'b00, 1, 1, 0, 16'h0000, 0);
      @(posedge clk); #1;
      check("pre-rst rv", rsp_valid, 1);
      check("pre-rst d1", rsp_data1, 16'h0101);
      drive(1, 2'b01, 0, 0, 3, 16'hDEAD, 0);
      rst = 1'b1;
      @(negedge clk);
      check("stalled write blocked", rf_writeReg, 0);
      @(posedge clk); #1;
      check("mid-rst rv", rsp_valid, 0);
      check("mid-rst err", err_op, 0);
      check("mid-rst done", init_done, 0);
      check("mid-rst d1", rsp_data1, 16'h0000);
      rst = 1'b0;
      req_valid = 1'b0;
      sweep_check("restart");
      drive(1, 2'b00, 3, 1, 0, 16'h0000, 1);
      @(posedge clk); #1;
      check("post-restart rv", rsp_valid, 1);
      check("post-restart d1", rsp_data1, 16'h0000);
      check("post-restart d2", rsp_data2, 16'h0000);
      req_valid = 1'b0;
      @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_port_sequencer.md
# regfile_port_sequencer

Request/response front-end that owns the ports of the 16 x 16-bit `RegisterFile`. After reset it sweeps all 16 registers to a known value. It then accepts read, write and write-then-read requests over a valid/ready handshake and drives the file's `srcReg_1/srcReg_2/dstReg/writeReg/dstData` lines. Read data is returned on a registered, back-pressurable response channel. It sits between the decode/writeback logic and `RegisterFile`, as the single master of that block.

## Interface
Parameters:
- `DATA_W`, 16, register width
- `INIT_VAL`, 16'h0000, value written to every register during the init sweep

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  sequencer can accept a request this cycle
- `req_op`  in  2  00 read, 01 write, 10 write-then-read, 11 reserved
- `req_src1`, `req_src2`  in  4 each  read register IDs
- `req_dst`  in  4  write register ID
- `req_data`  in  DATA_W  write data
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts response
- `rsp_data1`, `rsp_data2`  out  DATA_W each  read results for src1/src2
- `init_done`  out  1  init sweep complete
- `err_op`  out  1  sticky; set on acceptance of a reserved op
- `rf_srcReg_1`, `rf_srcReg_2`  out  4 each  to `RegisterFile` `srcReg_1/2`
- `rf_dstReg`  out  4  to `RegisterFile` `dstReg`
- `rf_writeReg`  out  1  to `RegisterFile` `writeReg`
- `rf_dstData`  out  DATA_W  to `RegisterFile` `dstData`
- `rf_srcData_1`, `rf_srcData_2`  in  DATA_W each  from `RegisterFile`; combinational read data

## Operation
- FSM states: INIT, IDLE, RESP.
- Reset puts every register into its reset state:
  - state = INIT, 4-bit sweep counter = 0.
  - `rsp_valid` = 0, `rsp_data1` = `rsp_data2` = 0.
  - `init_done` = 0, `err_op` = 0.
- INIT:
  - Drives `rf_writeReg` = 1, `rf_dstReg` = counter, `rf_dstData` = `INIT_VAL`.
  - `req_ready` = 0.
  - Counter increments each cycle. When counter = 15 at a clock edge, the FSM goes to IDLE and `init_done` is set to 1.
  - `init_done` stays 1 until the next reset.
- Accept condition is `fire = req_valid & req_ready`.
- `req_ready` = 1 in IDLE, and = `rsp_ready` in RESP.
- Outside INIT, read ports follow the request combinationally: `rf_srcReg_1` = `req_src1`, `rf_srcReg_2` = `req_src2`.
- Outside INIT, write port:
  - `rf_writeReg` = fire & (op = 01 | op = 10).
  - `rf_dstReg` = `req_dst`, `rf_dstData` = `req_data`.
- Behaviour on fire, by op:
  - op 00 (read): `rsp_data1/2` are loaded from `rf_srcData_1/2`; `rsp_valid` is set; next state is RESP.
  - op 01 (write): the register file is written at this edge. No response. Next state is IDLE, or IDLE after the pending response drains.
  - op 10 (write-then-read): the write is performed and a response is produced. Internal bypass applies: if `req_srcN` = `req_dst`, then `rsp_dataN` = `req_data`; otherwise `rsp_dataN` = `rf_srcDataN`. This holds whatever the file's write-through behaviour is.
  - op 11 (reserved): the request is consumed, `err_op` is set, and no write or response occurs.
- Response hold and drain in RESP:
  - Without `rsp_ready`, `rsp_valid` and the response data hold stable.
  - With `rsp_ready`, the response drains. A read-type request firing in the same cycle reloads the response, and `rsp_valid` stays 1. Otherwise `rsp_valid` goes to 0 and the state goes to IDLE.
- Registers hold 4-bit IDs. Values 0–15 are all valid, with no wrap logic needed. Data is passed through unmodified at `DATA_W` bits.

## Timing
- Init sweep occupies cycles 0–15 after the first edge with `rst` = 0. `init_done` = 1 and `req_ready` = 1 from cycle 16.
- Read latency: request accepted at edge N gives `rsp_valid` = 1 and valid data from edge N onward, i.e. visible in cycle N+1.
- Write latency: the register file is updated at the accepting edge. A read of the same register accepted at edge N+1 returns the new value.
- Throughput: one request per cycle when `rsp_ready` is held high.
- Back-pressure: while `rsp_valid` = 1 and `rsp_ready` = 0, `req_ready` = 0 and no request (including writes) is accepted.
- Reset asserted mid-operation (any state):
  - At the next edge the pending response is dropped, `rsp_valid` = 0 and `err_op` is cleared.
  - The init sweep restarts at register 0.
  - No partial request completes after that edge.
- `req_valid` during INIT: ignored; the requester must hold it until `req_ready`.

## Test plan
- Reset, release: `rf_writeReg` = 1 for exactly 16 cycles with `rf_dstReg` 0..15, then `init_done` = 1. Reading (src1 = 3, src2 = 15) returns 0x0000/0x0000 with `INIT_VAL` = 0.
- Write R5 = 0xBEEF, then read (5, 5) on the next cycle: `rsp_data1` = `rsp_data2` = 0xBEEF one cycle after accept.
- Write-then-read with dst = 7, data 0x1234, src1 = 7, src2 = 2 (R2 = 0x00AA): response is 0x1234/0x00AA; a later read of R7 returns 0x1234.
- Back-pressure: issue a read with `rsp_ready` = 0 for 3 cycles. `rsp_valid` and data stay stable, `req_ready` = 0, and a queued write of R9 = 0x5555 is not applied until the response drains.
- Back-to-back reads with `rsp_ready` = 1 for 8 cycles on R0..R7 (preloaded with 0x0100+i): one response per cycle, in order, with `rsp_valid` continuously 1.
- Reserved op 11: `err_op` rises, no `rf_writeReg` pulse, no response. `rst` asserted while a response is pending clears `rsp_valid` and `err_op` and restarts the 16-cycle sweep.
